recv_word_buffer: RTL
=====================

RECV_WORD_BUFFER -- requirements
Module: recv_word_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning FIFO capacity in 32-bit words; power of two, minimum 2.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on the clock edge).
REQ-004 SHALL have port rx_valid, input, 1, one-cycle strobe from the UART receiver; rx_data is valid this cycle.
REQ-005 SHALL have port rx_data, input, 8, received byte.
REQ-006 SHALL have port rx_error, input, 1, one-cycle framing-error strobe from the UART receiver.
REQ-007 SHALL expose the slave side of IRecvRequest as io_recv: en input 1 (pop request), rd output 32 (popped word), size output 32 (stored word count).
REQ-008 SHALL have port overflow, output, 1, sticky drop flag; present only per REQ-024.

Function
REQ-009 SHALL pack bytes little-endian: first byte of a word goes to bits 7:0, fourth byte to bits 31:24.
REQ-010 SHALL keep a 2-bit byte counter; each rx_valid stores rx_data at lane byte_cnt and increments byte_cnt.
REQ-011 SHALL push the assembled word in the same cycle as the fourth byte is accepted (byte_cnt == 3 with rx_valid); the push is visible in size on the next cycle; byte_cnt wraps to 0.
REQ-012 SHALL, on rx_error, discard the partial word and clear byte_cnt to 0; if rx_valid and rx_error are both high, rx_error wins and the byte is dropped.
REQ-013 SHALL, when the fourth byte completes while size == DEPTH and no pop happens that cycle, drop the word and leave the FIFO contents unchanged; byte_cnt still returns to 0.
REQ-014 SHALL treat io_recv.en with size > 0 as a pop: rd takes the head word on the next clock edge (one-cycle latency) and holds it until the next pop.
REQ-015 SHALL ignore io_recv.en when size == 0: rd, pointers and size are unchanged.
REQ-016 SHALL leave size unchanged on a same-cycle push and pop.
REQ-017 SHALL accept a push in the same cycle as a pop when full; no drop occurs.
REQ-018 SHALL use log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
REQ-019 SHALL derive full and empty from a separate count register (0..DEPTH), zero-extended onto size.
REQ-020 SHALL never return a word that is not yet visible in size: a pop issued on the push cycle of a word into an empty FIFO is ignored per REQ-015.

Reset
REQ-021 SHALL, while reset == 0, set size = 0, rd = 0, byte_cnt = 0, both pointers = 0, and overflow = 0.
REQ-022 SHALL discard any partial word and all stored words on reset, including reset asserted mid-word or mid-pop.
REQ-023 SHALL not require the storage array to be reset.

Configuration
REQ-024 SHALL, when RECV_OVERFLOW_FLAG_EN is defined, provide the overflow port and set it to 1 on every drop per REQ-013; it is cleared only by reset.
REQ-025 SHALL, when RECV_OVERFLOW_FLAG_EN is undefined, omit the overflow port and its register; drops are silent; all other behaviour is identical.

Verification
REQ-026 SHALL cover this: bytes 0x11,0x22,0x33,0x44 -> size becomes 1 the cycle after the 4th byte; en pulse -> rd = 0x44332211 the next cycle; size = 0.
REQ-027 SHALL cover this: bytes 0xAA,0xBB, then rx_error, then 0x01,0x02,0x03,0x04 -> exactly one word 0x04030201 is stored.
REQ-028 SHALL cover this: 4*DEPTH+4 bytes with no pops -> size = DEPTH; the extra word is dropped; overflow = 1 if enabled; pops return the first DEPTH words in order.
REQ-029 SHALL cover this: FIFO full, with 4th byte and en in the same cycle -> size stays DEPTH, no drop, overflow stays 0.
REQ-030 SHALL cover this: en with size = 0 -> rd keeps its previous value and size stays 0; then 2*DEPTH+3 push/pop pairs -> data is correct across pointer wrap.
REQ-031 SHALL cover this: reset pulled low after 2 bytes of a word -> after release, bytes 0x05,0x06,0x07,0x08 -> rd = 0x08070605, size = 0 before the push.

Source files
------------

// File: rtl/recv_word_buffer_if.sv
// Pop-request bundle between the receive word buffer and its consumer.
// The slave pops on en; rd is the popped word and size is the stored word count.
interface IRecvRequest;
  logic        en;
  logic [31:0] rd;
  logic [31:0] size;

  modport master (output en, input rd, size);
  modport slave  (input en, output rd, size);
endinterface

// File: rtl/recv_word_buffer.sv
// Packs UART bytes little-endian into 32-bit words and buffers them in a FIFO.
// Optional sticky drop flag on port overflow when RECV_OVERFLOW_FLAG_EN is defined.
module recv_word_buffer #(
  parameter int unsigned DEPTH = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  IRecvRequest.slave io_recv
`ifdef RECV_OVERFLOW_FLAG_EN
  ,
  output logic       overflow
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [1:0]      byte_cnt_q;
  logic [23:0]     partial_q;
  logic [31:0]     rd_q;

  logic        full, empty, pop, word_done, push;
  logic [31:0] word;

  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    pop       = io_recv.en && !empty;
    // rx_error beats rx_valid, so a byte seen with an error never completes a word.
    word_done = rx_valid && !rx_error && (byte_cnt_q == 2'd3);
    push      = word_done && (!full || pop);
    word      = {rx_data, partial_q};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      partial_q  <= '0;
      rd_q       <= '0;
    end else begin
      if (rx_error) begin
        byte_cnt_q <= '0;
      end else if (rx_valid) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    partial_q[7:0]   <= rx_data;
          2'd1:    partial_q[15:8]  <= rx_data;
          2'd2:    partial_q[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
        rd_q   <= mem[rptr_q];
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage is not reset; when full with a pop, the head is read before being overwritten.
  always_ff @(posedge clock) begin
    if (reset && push) mem[wptr_q] <= word;
  end

`ifdef RECV_OVERFLOW_FLAG_EN
  logic overflow_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (word_done && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  assign io_recv.rd   = rd_q;
  assign io_recv.size = 32'(count_q);

endmodule
